// File: rtl/args_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : args_pkg
//  Description : Shared definitions for the argument handshake transmitter:
//                FSM state encoding and a ceiling-log2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package args_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_SYNC = 2'd0;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd2;

    // Ceiling log2, never smaller than 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/args_sync.sv
`default_nettype none
// ============================================================================
//  Module      : args_sync
//  Description : N-flop single-bit resynchronizer for an asynchronous input.
//                The flops power up at INIT and have no functional reset, so a
//                local reset never disturbs what the chain has sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module args_sync #(
    parameter int   N    = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic din,
    output logic dout
);

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [N-1:0] chain = {N{INIT}};

    // Shift the asynchronous input through the metastability chain.
    always_ff @(posedge clk) begin
        chain <= {chain[N-2:0], din};
    end

    assign dout = chain[N-1];

endmodule
`default_nettype wire

// File: rtl/args_hs_tx.sv
`default_nettype none
// ============================================================================
//  Module      : args_hs_tx
//  Description : Source side of a two-phase (toggle) request/acknowledge CDC
//                handshake. Accepts one word on a valid/ready port, holds it
//                on tx_dat, toggles tx_req and waits for tx_ack to follow.
//  Revision    : 1.0  initial release
// ============================================================================
module args_hs_tx
    import args_pkg::*;
#(
    parameter int W       = 32,
    parameter int N_SYNC  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic         c,
    input  logic         r,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         tx_req,
    output logic [W-1:0] tx_dat,
    input  logic         tx_ack,
    output logic         tx_done,
    output logic         to_err
);

    localparam int                CNT_W   = clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam int                SET_W   = clog2(N_SYNC + 1);
    localparam logic [SET_W-1:0]  SET_MAX = SET_W'(N_SYNC);

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   to_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               ack_s;

    args_sync #(
        .N    (N_SYNC),
        .INIT (1'b0)
    ) u_ack_sync (
        .clk  (c),
        .din  (tx_ack),
        .dout (ack_s)
    );

    // Ready is a pure state decode so it never depends on in_vld.
    assign in_rdy = (state == ST_IDLE);

    // Handshake FSM, data holding register and timeout watchdog.
    // In SYNC the chain is first allowed to refill with N_SYNC fresh samples
    // so ack_s reflects the peer's current level, not pre-reset history.
    always_ff @(posedge c) begin
        if (r) begin
            state      <= ST_SYNC;
            tx_req     <= 1'b0;
            tx_dat     <= '0;
            tx_done    <= 1'b0;
            to_err     <= 1'b0;
            to_cnt     <= '0;
            settle_cnt <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_SYNC: begin
                    if (settle_cnt != SET_MAX) begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end else if (ack_s == tx_req) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (in_vld) begin
                        tx_dat <= in_dat;
                        tx_req <= ~tx_req;
                        to_cnt <= '0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A timeout only flags; the transfer keeps waiting.
                    if (to_cnt != CNT_MAX) begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end else begin
                        to_err <= 1'b1;
                    end
                    if (ack_s == tx_req) begin
                        tx_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_args_hs_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_args_hs_tx
//  Description : Self-checking bench for args_hs_tx: directed handshake
//                scenarios followed by randomized transfers against a
//                toggle-parity / latency reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_args_hs_tx;

    localparam int W  = 32;
    localparam int N  = 2;
    localparam int TO = 8;

    logic         c = 1'b0;
    logic         r = 1'b1;
    logic         in_vld = 1'b0;
    logic [W-1:0] in_dat = '0;
    logic         tx_ack = 1'b0;
    logic         in_rdy;
    logic         tx_req;
    logic [W-1:0] tx_dat;
    logic         tx_done;
    logic         to_err;

    int checks = 0;
    int errors = 0;

    int           dones, acc, unstable, spur, lat, gap, dly, bad, n;
    logic         prev_req, exp_req;
    logic [2:0]   reqseq;
    logic [W-1:0] words [3];
    logic [W-1:0] word;

    always #5 c = ~c;

    args_hs_tx #(
        .W       (W),
        .N_SYNC  (N),
        .TIMEOUT (TO)
    ) dut (
        .c       (c),
        .r       (r),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .in_rdy  (in_rdy),
        .tx_req  (tx_req),
        .tx_dat  (tx_dat),
        .tx_ack  (tx_ack),
        .tx_done (tx_done),
        .to_err  (to_err)
    );

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset with the peer idle at 0, then wait (bounded) for ready.
    task automatic reset_sync();
        r      = 1'b1;
        tx_ack = 1'b0;
        in_vld = 1'b0;
        repeat (4) tick();
        r = 1'b0;
        n = 0;
        while (!in_rdy && n < 20) begin
            tick();
            n++;
        end
        check("reset_sync_ready", in_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- Reset release with tx_ack = 0 and in_vld held high ----
        r = 1'b1; in_vld = 1'b1; in_dat = 32'hA5A5_A5A5; tx_ack = 1'b0;
        repeat (3) tick();
        check("rst_in_rdy",  in_rdy,  0);
        check("rst_tx_req",  tx_req,  0);
        check("rst_tx_dat",  tx_dat,  0);
        check("rst_tx_done", tx_done, 0);
        check("rst_to_err",  to_err,  0);
        r = 1'b0;
        for (int i = 1; i <= N; i++) begin
            tick();
            check("sync_in_rdy_low", in_rdy, 0);
            check("sync_no_accept",  tx_req, 0);
        end
        in_vld = 1'b0;
        tick();
        check("sync_release_rdy", in_rdy, 1);
        check("sync_release_req", tx_req, 0);
        check("sync_release_dat", tx_dat, 0);

        // ---- Single transfer ----
        in_dat = 32'hDEAD_BEEF; in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("single_req_toggle", tx_req, 1);
        check("single_dat",        tx_dat, 32'hDEAD_BEEF);
        check("single_rdy_low",    in_rdy, 0);
        repeat (5) begin
            tick();
            check("single_no_done", tx_done, 0);
            check("single_dat_hold", tx_dat, 32'hDEAD_BEEF);
        end
        tx_ack = 1'b1;
        for (int i = 1; i <= N; i++) begin
            tick();
            check("single_done_early", tx_done, 0);
            check("single_rdy_early",  in_rdy,  0);
        end
        tick();
        check("single_done", tx_done, 1);
        check("single_rdy",  in_rdy,  1);
        tick();
        check("single_done_one_cycle", tx_done, 0);

        // ---- Back-to-back with immediate-echo destination ----
        reset_sync();
        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
        dones = 0; acc = 0; unstable = 0; prev_req = 1'b0; reqseq = '0;
        in_dat = words[0]; in_vld = 1'b1;
        for (int cyc = 0; cyc < 40 && dones < 3; cyc++) begin
            tick();
            if (tx_done) dones++;
            if (tx_req !== prev_req) begin
                if (acc < 3) begin
                    reqseq[acc] = tx_req;
                    check("b2b_dat", tx_dat, words[acc]);
                end
                acc++;
                prev_req = tx_req;
                if (acc < 3) in_dat = words[acc];
                else         in_vld = 1'b0;
            end else if (acc > 0 && acc <= 3 && tx_dat !== words[acc-1]) begin
                unstable++;
            end
            tx_ack = tx_req;
        end
        check("b2b_dones",    dones,    3);
        check("b2b_accepts",  acc,      3);
        check("b2b_req_seq",  reqseq,   3'b101);
        check("b2b_dat_hold", unstable, 0);
        check("b2b_rdy_end",  in_rdy,   1);

        // ---- Spurious ack toggle while IDLE (req = 1, ack = 1) ----
        tx_ack = 1'b0;
        spur = 0;
        repeat (6) begin
            tick();
            if (tx_done) spur++;
            check("spur_rdy_high", in_rdy, 1);
        end
        check("spur_no_done", spur, 0);
        in_dat = 32'hCAFE_F00D; in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("spur_next_req", tx_req, 0);
        check("spur_next_dat", tx_dat, 32'hCAFE_F00D);
        tick();
        check("spur_next_done", tx_done, 1);
        check("spur_next_rdy",  in_rdy,  1);

        // ---- Timeout ----
        reset_sync();
        in_dat = 32'h1234_5678; in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            check("to_err_early", to_err, 0);
        end
        tick();
        check("to_err_set", to_err, 1);
        repeat (4) begin
            tick();
            check("to_err_hold", to_err,  1);
            check("to_no_done",  tx_done, 0);
            check("to_rdy_low",  in_rdy,  0);
        end
        tx_ack = 1'b1;
        lat = 0;
        while (!tx_done && lat < 10) begin
            tick();
            lat++;
        end
        check("to_late_latency", lat, N + 1);
        check("to_late_done",    tx_done, 1);
        check("to_err_sticky",   to_err,  1);
        tick();
        check("to_err_sticky2", to_err, 1);
        check("to_rdy_after",   in_rdy, 1);
        r = 1'b1;
        tick();
        check("to_err_cleared", to_err, 0);

        // ---- Reset mid-WAIT with an acknowledge in flight ----
        reset_sync();
        in_dat = 32'h0BAD_F00D; in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check("midwait_req", tx_req, 1);
        tx_ack = 1'b1;
        tick();
        r = 1'b1;
        repeat (3) tick();
        check("midwait_rst_req",  tx_req,  0);
        check("midwait_rst_dat",  tx_dat,  0);
        check("midwait_rst_done", tx_done, 0);
        check("midwait_rst_rdy",  in_rdy,  0);
        r = 1'b0;
        spur = 0;
        repeat (10) begin
            tick();
            if (tx_done) spur++;
            check("midwait_stale_rdy", in_rdy, 0);
        end
        tx_ack = 1'b0;
        for (int i = 1; i <= N; i++) begin
            tick();
            if (tx_done) spur++;
            check("midwait_release_early", in_rdy, 0);
        end
        tick();
        if (tx_done) spur++;
        check("midwait_release_rdy", in_rdy, 1);
        check("midwait_no_done",     spur,   0);

        // ---- Randomized transfers vs. parity/latency model ----
        exp_req = 1'b0;
        bad = 0;
        for (int t = 0; t < 24; t++) begin
            word = $urandom;
            gap  = $urandom_range(0, 3);
            dly  = $urandom_range(0, 4);
            repeat (gap) begin
                tick();
                if (tx_done) bad++;
            end
            in_dat = word; in_vld = 1'b1;
            tick();
            in_vld  = 1'b0;
            exp_req = ~exp_req;
            check("rnd_req",     tx_req, exp_req);
            check("rnd_dat",     tx_dat, word);
            check("rnd_rdy_low", in_rdy, 0);
            repeat (dly) begin
                tick();
                if (tx_dat !== word || tx_done) bad++;
            end
            tx_ack = exp_req;
            lat = 0;
            while (!tx_done && lat < 10) begin
                tick();
                lat++;
                if (tx_dat !== word) bad++;
            end
            check("rnd_latency", lat,    N + 1);
            check("rnd_rdy_end", in_rdy, 1);
        end
        check("rnd_hold",   bad,    0);
        check("rnd_to_err", to_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
